// File: rtl/hdr_field_decode_if.sv
// ---------------------------------------------------------------------------
// hdr_field_decode_if
//   Bundles the packet-side signals of the cardinal-router header decoder.
//   slave  : seen by the decoder (takes pkt/in_valid, drives decode + route)
//   master : seen by whoever supplies flits and consumes the results
//
//   pkt        packet under decode (64 bits)
//   in_valid   pkt is a live flit to route this cycle
//   vc..payload  combinational header/payload slices of pkt
//   out_valid  registered route result valid
//   route      one-hot {PE,S,N,W,E}
//   pkt_next   pkt with the consumed hop decremented
// ---------------------------------------------------------------------------
interface hdr_field_decode_if;
    logic [63:0] pkt;
    logic        in_valid;

    logic        vc;
    logic        dx;
    logic        dy;
    logic [4:0]  rsv;
    logic [3:0]  hx;
    logic [3:0]  hy;
    logic [7:0]  srcx;
    logic [7:0]  srcy;
    logic [31:0] payload;

    logic        out_valid;
    logic [4:0]  route;
    logic [63:0] pkt_next;

    modport slave (
        input  pkt, in_valid,
        output vc, dx, dy, rsv, hx, hy, srcx, srcy, payload,
        output out_valid, route, pkt_next
    );

    modport master (
        output pkt, in_valid,
        input  vc, dx, dy, rsv, hx, hy, srcx, srcy, payload,
        input  out_valid, route, pkt_next
    );
endinterface

// File: rtl/hdr_field_decode.sv
// ---------------------------------------------------------------------------
// hdr_field_decode
//   Header field decoder for the cardinal-router 64-bit packet plus a single
//   registered XY route / hop-update stage.
//
//   Layout: [63] vc | [62] dx | [61] dy | [60:56] rsv | [55:52] hx |
//           [51:48] hy | [47:40] srcx | [39:32] srcy | [31:0] payload
//
//   Ports
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    hdr_field_decode_if.slave
//              in : pkt, in_valid
//              out: vc, dx, dy, rsv, hx, hy, srcx, srcy, payload (zero latency)
//                   out_valid, route, pkt_next (one cycle after in_valid)
// ---------------------------------------------------------------------------
module hdr_field_decode #(
    parameter int PKT_W   = 64,
    parameter int HDR_LSB = 32
) (
    input  logic                clk,
    input  logic                reset,
    hdr_field_decode_if.slave   bus
);

    // One-hot route encodings, bit order {PE,S,N,W,E}
    localparam logic [4:0] ROUTE_E  = 5'b00001;
    localparam logic [4:0] ROUTE_W  = 5'b00010;
    localparam logic [4:0] ROUTE_N  = 5'b00100;
    localparam logic [4:0] ROUTE_S  = 5'b01000;
    localparam logic [4:0] ROUTE_PE = 5'b10000;

    logic [3:0]       hx;
    logic [3:0]       hy;

    logic             out_valid_d, out_valid_q;
    logic [4:0]       route_d,     route_q;
    logic [PKT_W-1:0] pkt_next_d,  pkt_next_q;

    assign hx = bus.pkt[55:52];
    assign hy = bus.pkt[51:48];

    // Pure field slicing; unaffected by reset or in_valid so debug/NIC logic
    // always sees the current packet.
    assign bus.vc      = bus.pkt[63];
    assign bus.dx      = bus.pkt[62];
    assign bus.dy      = bus.pkt[61];
    assign bus.rsv     = bus.pkt[60:56];
    assign bus.hx      = hx;
    assign bus.hy      = hy;
    assign bus.srcx    = bus.pkt[47:40];
    assign bus.srcy    = bus.pkt[39:32];
    assign bus.payload = bus.pkt[HDR_LSB-1:0];

    // XY dimension-order routing. X hops are consumed before Y hops; a zero
    // hop field is never decremented, so it cannot wrap to 4'hF. Without a
    // live flit the route and packet registers keep their previous contents.
    always_comb begin
        out_valid_d = bus.in_valid;
        route_d     = route_q;
        pkt_next_d  = pkt_next_q;
        if (bus.in_valid) begin
            pkt_next_d = bus.pkt;
            if (hx != 4'd0) begin
                route_d           = bus.pkt[62] ? ROUTE_W : ROUTE_E;
                pkt_next_d[55:52] = hx - 4'd1;
            end else if (hy != 4'd0) begin
                route_d           = bus.pkt[61] ? ROUTE_S : ROUTE_N;
                pkt_next_d[51:48] = hy - 4'd1;
            end else begin
                route_d = ROUTE_PE;
            end
        end
    end

    // Result registers; reset overrides any flit presented on the same edge
    // so an in-flight result is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            route_q     <= 5'b0;
            pkt_next_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            route_q     <= route_d;
            pkt_next_q  <= pkt_next_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.route     = route_q;
    assign bus.pkt_next  = pkt_next_q;

endmodule

// File: tb/tb_hdr_field_decode.sv
// ---------------------------------------------------------------------------
// tb_hdr_field_decode
//   Self-checking bench for hdr_field_decode. Decode outputs are compared
//   against a table of hand-derived field values; registered route results
//   are predicted when a flit is driven and compared by a monitor one cycle
//   later. Idle cycles check that route/pkt_next hold.
// ---------------------------------------------------------------------------
module tb_hdr_field_decode;

    typedef struct {
        logic [63:0] pkt;
        logic        vc;
        logic        dx;
        logic        dy;
        logic [4:0]  rsv;
        logic [3:0]  hx;
        logic [3:0]  hy;
        logic [7:0]  srcx;
        logic [7:0]  srcy;
        logic [31:0] payload;
        logic [4:0]  route;
        logic [63:0] nxt;
    } vec_t;

    typedef struct packed {
        logic [4:0]  route;
        logic [63:0] nxt;
    } exp_t;

    localparam int NVEC = 10;

    logic clk;
    logic reset;

    hdr_field_decode_if bus ();

    hdr_field_decode #(.PKT_W(64), .HDR_LSB(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    vec_t        vecs [NVEC];
    exp_t        exp_q [$];
    logic [4:0]  hold_route;
    logic [63:0] hold_next;
    logic        mon_en;
    int          n_total;
    int          n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus 2 time units after a rising edge and
    // predicts the result the following edge should produce.
    task automatic applyStimulus(input logic [63:0] p, input logic v, input logic r,
                                 input logic [4:0] er, input logic [63:0] en);
        exp_t e;
        @(posedge clk);
        #2;
        bus.pkt      = p;
        bus.in_valid = v;
        reset        = r;
        if (v && !r) begin
            e.route = er;
            e.nxt   = en;
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic checkDecode(input string tag, input vec_t v);
        checkOutput({tag, "_vc"},      64'(bus.vc),      64'(v.vc));
        checkOutput({tag, "_dx"},      64'(bus.dx),      64'(v.dx));
        checkOutput({tag, "_dy"},      64'(bus.dy),      64'(v.dy));
        checkOutput({tag, "_rsv"},     64'(bus.rsv),     64'(v.rsv));
        checkOutput({tag, "_hx"},      64'(bus.hx),      64'(v.hx));
        checkOutput({tag, "_hy"},      64'(bus.hy),      64'(v.hy));
        checkOutput({tag, "_srcx"},    64'(bus.srcx),    64'(v.srcx));
        checkOutput({tag, "_srcy"},    64'(bus.srcy),    64'(v.srcy));
        checkOutput({tag, "_payload"}, 64'(bus.payload), 64'(v.payload));
    endtask

    // Monitor: 1 time unit after each rising edge, compare the registered
    // outputs against reset values, the scoreboard head, or the held values.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (reset) begin
                checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
                checkOutput("rst_route",     64'(bus.route),     64'd0);
                checkOutput("rst_pkt_next",  bus.pkt_next,       64'd0);
                exp_q.delete();
                hold_route = 5'b0;
                hold_next  = 64'b0;
            end else begin
                checkOutput("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("route",    64'(bus.route), 64'(e.route));
                    checkOutput("pkt_next", bus.pkt_next,   e.nxt);
                    hold_route = e.route;
                    hold_next  = e.nxt;
                end else begin
                    checkOutput("held_route",    64'(bus.route), 64'(hold_route));
                    checkOutput("held_pkt_next", bus.pkt_next,   hold_next);
                end
            end
        end
    end

    initial begin
        vec_t v;
        n_total      = 0;
        n_pass       = 0;
        mon_en       = 1'b0;
        hold_route   = 5'b0;
        hold_next    = 64'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.pkt      = 64'b0;

        //           pkt                     vc dx dy rsv    hx    hy    srcx   srcy   payload        route     nxt
        vecs[0] = '{64'h8000_0000_0000_0000, 1, 0, 0, 5'h00, 4'h0, 4'h0, 8'h00, 8'h00, 32'h0000_0000, 5'b10000, 64'h8000_0000_0000_0000};
        vecs[1] = '{64'h4032_0507_DEAD_BEEF, 0, 1, 0, 5'h00, 4'h3, 4'h2, 8'h05, 8'h07, 32'hDEAD_BEEF, 5'b00010, 64'h4022_0507_DEAD_BEEF};
        vecs[2] = '{64'h0002_0000_0000_0001, 0, 0, 0, 5'h00, 4'h0, 4'h2, 8'h00, 8'h00, 32'h0000_0001, 5'b00100, 64'h0001_0000_0000_0001};
        vecs[3] = '{64'h2002_0000_0000_0001, 0, 0, 1, 5'h00, 4'h0, 4'h2, 8'h00, 8'h00, 32'h0000_0001, 5'b01000, 64'h2001_0000_0000_0001};
        vecs[4] = '{64'h1F00_0304_0000_0000, 0, 0, 0, 5'h1F, 4'h0, 4'h0, 8'h03, 8'h04, 32'h0000_0000, 5'b10000, 64'h1F00_0304_0000_0000};
        vecs[5] = '{64'h000F_0000_0000_0000, 0, 0, 0, 5'h00, 4'h0, 4'hF, 8'h00, 8'h00, 32'h0000_0000, 5'b00100, 64'h000E_0000_0000_0000};
        vecs[6] = '{64'h0010_1234_5678_9ABC, 0, 0, 0, 5'h00, 4'h1, 4'h0, 8'h12, 8'h34, 32'h5678_9ABC, 5'b00001, 64'h0000_1234_5678_9ABC};
        vecs[7] = '{64'h40F5_AA55_0000_FFFF, 0, 1, 0, 5'h00, 4'hF, 4'h5, 8'hAA, 8'h55, 32'h0000_FFFF, 5'b00010, 64'h40E5_AA55_0000_FFFF};
        vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 5'h1F, 4'hF, 4'hF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 5'b00010, 64'hFFEF_FFFF_FFFF_FFFF};
        vecs[9] = '{64'h2001_0000_0000_0000, 0, 0, 1, 5'h00, 4'h0, 4'h1, 8'h00, 8'h00, 32'h0000_0000, 5'b01000, 64'h2000_0000_0000_0000};

        $display("[TB] start");
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // Reset wins over a live flit on the same edge.
        applyStimulus(vecs[1].pkt, 1'b1, 1'b1, 5'b0, 64'b0);
        checkDecode("rst_dec", vecs[1]);

        // Table sweep, back-to-back valid flits.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].pkt, 1'b1, 1'b0, vecs[i].route, vecs[i].nxt);
            checkDecode($sformatf("v%0d", i), vecs[i]);
        end

        // Idle with a changing pkt: decode tracks, registered results hold.
        applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 5'b0, 64'b0);
        checkOutput("idle_rsv", 64'(bus.rsv), 64'h01);
        checkOutput("idle_hx",  64'(bus.hx),  64'h2);
        checkOutput("idle_hy",  64'(bus.hy),  64'h3);
        applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 5'b0, 64'b0);

        // Three back-to-back flits then idle: out_valid for exactly three cycles.
        applyStimulus(vecs[1].pkt, 1'b1, 1'b0, vecs[1].route, vecs[1].nxt);
        applyStimulus(vecs[2].pkt, 1'b1, 1'b0, vecs[2].route, vecs[2].nxt);
        applyStimulus(vecs[4].pkt, 1'b1, 1'b0, vecs[4].route, vecs[4].nxt);
        applyStimulus(vecs[6].pkt, 1'b0, 1'b0, 5'b0, 64'b0);
        applyStimulus(vecs[7].pkt, 1'b0, 1'b0, 5'b0, 64'b0);

        // Gapped traffic: valid, idle, valid.
        applyStimulus(vecs[3].pkt, 1'b1, 1'b0, vecs[3].route, vecs[3].nxt);
        applyStimulus(vecs[5].pkt, 1'b0, 1'b0, 5'b0, 64'b0);
        applyStimulus(vecs[9].pkt, 1'b1, 1'b0, vecs[9].route, vecs[9].nxt);

        // Reset mid-stream: the flit presented with reset is dropped, outputs
        // clear and then stay cleared while idle.
        applyStimulus(vecs[7].pkt, 1'b1, 1'b0, vecs[7].route, vecs[7].nxt);
        applyStimulus(vecs[8].pkt, 1'b1, 1'b1, 5'b0, 64'b0);
        checkDecode("midrst_dec", vecs[8]);
        applyStimulus(vecs[8].pkt, 1'b0, 1'b0, 5'b0, 64'b0);
        applyStimulus(vecs[0].pkt, 1'b1, 1'b0, vecs[0].route, vecs[0].nxt);
        applyStimulus(vecs[0].pkt, 1'b0, 1'b0, 5'b0, 64'b0);
        applyStimulus(vecs[0].pkt, 1'b0, 1'b0, 5'b0, 64'b0);

        checkOutput("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
